// File: rtl/laby7_counter.sv
// Modulo-N up/down counter with parallel load (saturating), terminal-count flag
// and a Gray-coded mirror of the count.
module laby7_counter #(
   parameter int WIDTH     = 4,
   parameter int MODULO    = 16,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic [WIDTH-1:0] cnt_gray,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

   logic             at_max;
   logic             at_min;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] load_sat;

   assign at_max = (cnt == MAXV);
   assign at_min = (cnt == '0);

   // Out-of-range load values clamp to the top of the modulus so cnt never leaves 0..MODULO-1.
   assign load_sat = (load_val > MAXV) ? MAXV : load_val;

   always_comb begin
      cnt_nxt = cnt;
      if (load)
         cnt_nxt = load_sat;
      else if (en) begin
         if (up_dn)
            cnt_nxt = at_max ? '0 : cnt + 1'b1;
         else
            cnt_nxt = at_min ? MAXV : cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= RSTV;
      else
         cnt <= cnt_nxt;
   end

   assign cnt_gray = cnt ^ (cnt >> 1);
   assign tc       = en & (up_dn ? at_max : at_min);

endmodule

// File: tb/tb_laby7_counter.sv
// Directed bench for laby7_counter: a default (mod 16) and a mod-10 instance share
// stimulus; a modulo-arithmetic model is compared every cycle, plus literal checks.
module tb_laby7_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] cnt16, gray16, cnt10, gray10;
   logic       tc16, tc10;
   logic       chk_on = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int m16 = 0;
   int m10 = 0;

   laby7_counter #(.WIDTH(4), .MODULO(16), .RESET_VAL(0)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .cnt(cnt16), .cnt_gray(gray16), .tc(tc16));

   laby7_counter #(.WIDTH(4), .MODULO(10), .RESET_VAL(0)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .cnt(cnt10), .cnt_gray(gray10), .tc(tc10));

   always #10 clk = ~clk;

   function automatic int nxt(int m, int md);
      if (load) return (int'(load_val) < md) ? int'(load_val) : md - 1;
      if (en) return up_dn ? (m + 1) % md : (m + md - 1) % md;
      return m;
   endfunction

   function automatic int gray_of(int v);
      return v ^ (v >> 1);
   endfunction

   function automatic int tc_of(int v, int md);
      return (en && ((up_dn && v == md - 1) || (!up_dn && v == 0))) ? 1 : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m16 <= 0;
         m10 <= 0;
      end else begin
         m16 <= nxt(m16, 16);
         m10 <= nxt(m10, 10);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model cnt16", int'(cnt16), m16);
         chk("model gray16", int'(gray16), gray_of(m16));
         chk("model tc16", int'(tc16), tc_of(m16, 16));
         chk("model cnt10", int'(cnt10), m10);
         chk("model gray10", int'(gray10), gray_of(m10));
         chk("model tc10", int'(tc10), tc_of(m10, 10));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_load(input logic [3:0] v);
      load = 1'b1;
      load_val = v;
      step(1);
      load = 1'b0;
   endtask

   initial begin
      // Reset asserted between edges, before any clock has sampled it.
      #3 rst_n = 1'b0;
      up_dn = 1'b0;
      #1;
      chk("rst cnt", int'(cnt16), 0);
      chk("rst gray", int'(gray16), 0);
      chk("rst tc en0", int'(tc16), 0);
      en = 1'b1;
      #1;
      chk("tc down at 0", int'(tc16), 1);
      up_dn = 1'b1;
      #1;
      chk("tc up at 0", int'(tc16), 0);
      chk_on = 1'b1;
      #9 rst_n = 1'b1;

      // Free run: 20 edges -> 1..15, 0, 1..4.
      for (int i = 1; i <= 20; i++) begin
         step(1);
         chk("run cnt", int'(cnt16), i % 16);
         chk("run tc", int'(tc16), (i % 16 == 15) ? 1 : 0);
         if (i == 15) chk("gray at 15", int'(gray16), 8);
      end

      // Down count from a load of 2.
      do_load(4'd2);
      chk("load 2", int'(cnt16), 2);
      up_dn = 1'b0;
      step(1); chk("down 1", int'(cnt16), 1);
      step(1); chk("down 0", int'(cnt16), 0);
      chk("tc down 0", int'(tc16), 1);
      step(1); chk("down wrap 15", int'(cnt16), 15);
      chk("tc at 15 down", int'(tc16), 0);
      step(1); chk("down 14", int'(cnt16), 14);

      // Hold, then load beats enable.
      up_dn = 1'b1;
      do_load(4'd7);
      en = 1'b0;
      step(5);
      chk("hold 7", int'(cnt16), 7);
      chk("hold tc", int'(tc16), 0);
      en = 1'b1;
      do_load(4'd3);
      chk("load wins", int'(cnt16), 3);

      // Modulo-10 instance: up count, saturation, down wrap.
      do_load(4'd0);
      for (int i = 1; i <= 10; i++) begin
         step(1);
         chk("mod10 cnt", int'(cnt10), i % 10);
         chk("mod10 tc", int'(tc10), (i % 10 == 9) ? 1 : 0);
      end
      do_load(4'd12);
      chk("mod10 sat", int'(cnt10), 9);
      chk("mod16 load 12", int'(cnt16), 12);
      do_load(4'd0);
      up_dn = 1'b0;
      step(1);
      chk("mod10 down wrap", int'(cnt10), 9);
      chk("mod16 down wrap", int'(cnt16), 15);

      // Asynchronous reset mid-count.
      up_dn = 1'b1;
      do_load(4'd11);
      #5 rst_n = 1'b0;
      #1;
      chk("async rst cnt16", int'(cnt16), 0);
      chk("async rst cnt10", int'(cnt10), 0);
      #8 rst_n = 1'b1;
      step(1); chk("resume 1", int'(cnt16), 1);
      step(1); chk("resume 2", int'(cnt16), 2);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
